// File: rtl/pam_4_slicer_deser.sv
`default_nettype none
// ============================================================================
// Module      : pam_4_slicer_deser
// Description : PAM-4 receive slicer, symbol-to-word packer and one-entry
//               valid/ready output buffer with outlier and drop statistics.
// Revision    : 1.0 - initial release
// ============================================================================

module pam_4_slicer_deser #(
   parameter int SIGNAL_RESOLUTION = 10,
   parameter int SYMBOL_SEPERATION = 56,
   parameter int WORD_SYMBOLS      = 4,
   parameter int OUTLIER_THRESH    = 140
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic signed [SIGNAL_RESOLUTION-1:0] voltage_level_in,
   input  logic                                voltage_level_in_valid,
   input  logic                                realign,
   output logic [1:0]                          symbol_out,
   output logic                                symbol_out_valid,
   output logic [2*WORD_SYMBOLS-1:0]           word_out,
   output logic                                word_out_valid,
   input  logic                                word_out_ready,
   output logic                                overflow,
   output logic [15:0]                         outlier_count,
   input  logic                                stats_clear
);

   localparam int WW = 2 * WORD_SYMBOLS;
   localparam int CW = $clog2(WORD_SYMBOLS + 1);

   localparam logic signed [SIGNAL_RESOLUTION-1:0] C_POS_SEP =
      SIGNAL_RESOLUTION'(SYMBOL_SEPERATION);
   localparam logic signed [SIGNAL_RESOLUTION-1:0] C_NEG_SEP =
      SIGNAL_RESOLUTION'(-SYMBOL_SEPERATION);
   localparam logic signed [SIGNAL_RESOLUTION-1:0] C_POS_OT  =
      SIGNAL_RESOLUTION'(OUTLIER_THRESH);
   localparam logic signed [SIGNAL_RESOLUTION-1:0] C_NEG_OT  =
      SIGNAL_RESOLUTION'(-OUTLIER_THRESH);
   localparam logic [CW-1:0] C_LAST_IDX = CW'(WORD_SYMBOLS - 1);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_t;

   // ------------------------------------------------------------------------
   // Stage 1: slicer and outlier statistics
   // ------------------------------------------------------------------------
   logic [1:0]  slice_sym;
   logic        is_outlier;
   logic [1:0]  sym_q, sym_d;
   logic        sym_valid_q, sym_valid_d;
   logic [15:0] outlier_q, outlier_d;

   // Exact threshold values fall into the upper symbol.
   always_comb begin
      slice_sym = 2'b00;
      if (voltage_level_in >= C_POS_SEP) begin
         slice_sym = 2'b11;
      end else if (!voltage_level_in[SIGNAL_RESOLUTION-1]) begin
         slice_sym = 2'b10;
      end else if (voltage_level_in >= C_NEG_SEP) begin
         slice_sym = 2'b01;
      end
   end

   assign is_outlier = (voltage_level_in >= C_POS_OT) ||
                       (voltage_level_in <= C_NEG_OT);

   always_comb begin
      sym_d       = sym_q;
      sym_valid_d = 1'b0;
      outlier_d   = outlier_q;
      if (voltage_level_in_valid) begin
         sym_d       = slice_sym;
         sym_valid_d = 1'b1;
      end
      if (stats_clear) begin
         outlier_d = '0;
      end else if (voltage_level_in_valid && is_outlier &&
                   (outlier_q != 16'hFFFF)) begin
         outlier_d = outlier_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sym_q       <= '0;
         sym_valid_q <= 1'b0;
         outlier_q   <= '0;
      end else begin
         sym_q       <= sym_d;
         sym_valid_q <= sym_valid_d;
         outlier_q   <= outlier_d;
      end
   end

   assign symbol_out       = sym_q;
   assign symbol_out_valid = sym_valid_q;
   assign outlier_count    = outlier_q;

   // ------------------------------------------------------------------------
   // Stage 2: packer; completed words are registered before the buffer
   // ------------------------------------------------------------------------
   logic [WW-1:0] shift_q, shift_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic [WW-1:0] done_word_q, done_word_d;
   logic [WW-1:0] shift_base;
   logic [CW-1:0] cnt_base;
   logic [WW-1:0] shift_next;

   // realign wipes the partial word first, so a coincident symbol starts the new word.
   always_comb begin
      shift_base  = realign ? '0 : shift_q;
      cnt_base    = realign ? '0 : cnt_q;
      shift_next  = {shift_base[WW-3:0], sym_q};
      shift_d     = shift_base;
      cnt_d       = cnt_base;
      done_d      = 1'b0;
      done_word_d = done_word_q;
      if (sym_valid_q) begin
         if (cnt_base == C_LAST_IDX) begin
            done_d      = 1'b1;
            done_word_d = shift_next;
            shift_d     = '0;
            cnt_d       = '0;
         end else begin
            shift_d = shift_next;
            cnt_d   = cnt_base + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         shift_q     <= '0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         done_word_q <= '0;
      end else begin
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         done_word_q <= done_word_d;
      end
   end

   // ------------------------------------------------------------------------
   // Output buffer
   // ------------------------------------------------------------------------
   buf_state_t    state_q, state_d;
   logic [WW-1:0] word_q, word_d;
   logic          overflow_q, overflow_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_EMPTY;
         word_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      overflow_d = overflow_q;
      case (state_q)
         ST_EMPTY: begin
            if (done_q) begin
               word_d  = done_word_q;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (done_q) begin
               // A stalled consumer keeps the held word; the new one is lost.
               if (word_out_ready) begin
                  word_d = done_word_q;
               end else begin
                  overflow_d = 1'b1;
               end
            end else if (word_out_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      if (stats_clear) begin
         overflow_d = 1'b0;
      end
   end

   assign word_out       = word_q;
   assign word_out_valid = (state_q == ST_FULL);
   assign overflow       = overflow_q;

endmodule

`default_nettype wire
